// File: rtl/attention_row_streamer_if.sv
// Bundle between the attention datapath, this streamer and the downstream
// writeback path.
//   master : drives the attention bundle (attention_vld, attention0..7),
//            the downstream ready (out_rdy) and ovf_clr; observes the row
//            stream and status.
//   slave  : the streamer itself; the mirror image of master.
// Element (r,c) of head h sits at attentionh[(r*64+c)*DATA_WIDTH +: DATA_WIDTH];
// column c of out_data sits at out_data[c*DATA_WIDTH +: DATA_WIDTH].
interface attention_row_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int ROW_W = 64 * DATA_WIDTH;
  localparam int MAT_W = 64 * ROW_W;

  logic             attention_vld;
  logic [MAT_W-1:0] attention0;
  logic [MAT_W-1:0] attention1;
  logic [MAT_W-1:0] attention2;
  logic [MAT_W-1:0] attention3;
  logic [MAT_W-1:0] attention4;
  logic [MAT_W-1:0] attention5;
  logic [MAT_W-1:0] attention6;
  logic [MAT_W-1:0] attention7;

  logic             out_vld;
  logic             out_rdy;
  logic [ROW_W-1:0] out_data;
  logic [2:0]       out_head;
  logic [5:0]       out_row;
  logic             out_last;

  logic             frame_done;
  logic             busy;
  logic             ovf;
  logic             ovf_clr;
  logic [15:0]      frame_cnt;

  modport master (
    output attention_vld,
    output attention0, attention1, attention2, attention3,
    output attention4, attention5, attention6, attention7,
    output out_rdy,
    output ovf_clr,
    input  out_vld, out_data, out_head, out_row, out_last,
    input  frame_done, busy, ovf, frame_cnt
  );

  modport slave (
    input  attention_vld,
    input  attention0, attention1, attention2, attention3,
    input  attention4, attention5, attention6, attention7,
    input  out_rdy,
    input  ovf_clr,
    output out_vld, out_data, out_head, out_row, out_last,
    output frame_done, busy, ovf, frame_cnt
  );
endinterface

// File: rtl/attention_row_streamer.sv
// attention_row_streamer
// Captures one attention frame (eight 64x64 head matrices) on an
// attention_vld pulse and replays it as 512 row beats over a valid/ready
// handshake, head 0..7 outer, row 0..63 inner.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (frame buffer is not cleared)
//   bus    : attention_row_streamer_if.slave
//            in : attention_vld, attention0..7, out_rdy, ovf_clr
//            out: out_vld, out_data, out_head, out_row, out_last,
//                 frame_done, busy, ovf, frame_cnt
module attention_row_streamer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  attention_row_streamer_if.slave  bus
);

  localparam int         ROW_W     = 64 * DATA_WIDTH;
  localparam int         MAT_W     = 64 * ROW_W;
  localparam int         FRAME_W   = 8 * MAT_W;
  localparam logic [8:0] LAST_BEAT = 9'd511;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;

  // Flat frame image: beat b = head*64 + row lives at [b*ROW_W +: ROW_W],
  // which is exactly the concatenation {attention7, ..., attention0}.
  logic [FRAME_W-1:0] frame_buf;

  logic [8:0]         beat_q;
  logic               frame_done_q;
  logic               ovf_q;
  logic [15:0]        frame_cnt_q;

  logic               out_vld;
  logic               out_last;
  logic [ROW_W-1:0]   out_data;

  logic               xfer;
  logic               last_xfer;
  logic               capture;
  logic               drop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A capture coinciding with the final transfer keeps
  // the machine in SEND so back-to-back frames stream without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.attention_vld) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_xfer && !bus.attention_vld) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. out_data is gated to zero outside SEND so the
  // uninitialised buffer never shows up on the bus after reset.
  always_comb begin
    out_vld  = (state_q == SEND);
    out_last = out_vld && (beat_q == LAST_BEAT);
    out_data = '0;
    if (out_vld) begin
      out_data = frame_buf[beat_q*ROW_W +: ROW_W];
    end
  end

  // Handshake decode
  always_comb begin
    xfer      = out_vld && bus.out_rdy;
    last_xfer = xfer && (beat_q == LAST_BEAT);
    // Only an idle block or the final transfer of a frame may accept a
    // new frame; anything else would overwrite rows still being sent.
    capture   = bus.attention_vld && ((state_q == IDLE) || last_xfer);
    drop      = bus.attention_vld && (state_q == SEND) && !last_xfer;
  end

  // Frame buffer: data only, no reset, written solely on capture
  always_ff @(posedge clk) begin
    if (capture) begin
      frame_buf <= {bus.attention7, bus.attention6, bus.attention5, bus.attention4,
                    bus.attention3, bus.attention2, bus.attention1, bus.attention0};
    end
  end

  // Beat pointer: {head, row}. Incrementing past 511 wraps to 0, which
  // also leaves head/row at 0 when the block returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (capture) begin
      beat_q <= '0;
    end else if (xfer) begin
      beat_q <= beat_q + 9'd1;
    end
  end

  // Frame completion and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      frame_done_q <= last_xfer;
      if (last_xfer) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      // A fresh overflow takes priority over a clear in the same cycle.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.out_vld    = out_vld;
  assign bus.out_data   = out_data;
  assign bus.out_head   = beat_q[8:6];
  assign bus.out_row    = beat_q[5:0];
  assign bus.out_last   = out_last;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = out_vld;
  assign bus.ovf        = ovf_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: doc/attention_row_streamer.md
Name: attention_row_streamer

Overview:
- Consumer end of the attention output bundle: attention_vld plus eight 64x64 matrices attention0..attention7, each DATA_WIDTH bits per element.
- On attention_vld, captures all eight heads into an internal frame buffer.
- Streams the frame out one 64-element row per beat over a valid/ready handshake, head 0 to head 7, row 0 to row 63.
- Sits between the transformer attention datapath and the downstream writeback/checker path.

Parameters:
- DATA_WIDTH, 16, element width in bits; must match the producing bundle.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- attention_vld  input  1  one-cycle pulse; attention0..7 are valid this cycle
- attention0..attention7  input  64*64*DATA_WIDTH each  head matrices; element (r,c) at bits [(r*64+c)*DATA_WIDTH +: DATA_WIDTH]
- out_vld  output  1  row beat valid
- out_rdy  input  1  downstream accepts the beat
- out_data  output  64*DATA_WIDTH  row r of head h = attentionh[r*64*DATA_WIDTH +: 64*DATA_WIDTH]; column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_head  output  3  head index of the current beat
- out_row  output  6  row index of the current beat
- out_last  output  1  high with the head 7 / row 63 beat
- frame_done  output  1  one-cycle pulse after the last beat handshake
- busy  output  1  high while in SEND
- ovf  output  1  sticky; a frame was dropped
- ovf_clr  input  1  clears ovf
- frame_cnt  output  16  count of completed frames; wraps 0xFFFF to 0

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; out_vld=0, out_head=0, out_row=0, out_last=0, frame_done=0, busy=0, ovf=0, frame_cnt=0, out_data=0. The frame buffer is not cleared.
- Reset mid-stream aborts the frame immediately: no frame_done, frame_cnt unchanged.
- Handshake: a beat transfers on a cycle with out_vld && out_rdy. While out_vld=1 and out_rdy=0, out_data, out_head, out_row and out_last hold stable. out_vld never drops without a transfer.
- State IDLE:
  - attention_vld=1 captures all eight heads and enters SEND next cycle.
  - Latency: out_vld=1 with head 0 / row 0 in the cycle after the vld pulse.
- State SEND:
  - busy=1, out_vld=1.
  - On each transfer, the row advances; after row 63 the row wraps to 0 and the head increments.
  - Transfer with head=7 and row=63: out_last=1 on that beat. Next cycle: frame_done=1, frame_cnt+1, and return to IDLE (out_vld=0).
- Back-to-back frames: if attention_vld=1 in the same cycle as the out_last transfer, the new frame is captured and the block stays in SEND.
  - Next cycle: head 0 / row 0 of the new frame with out_vld=1, frame_done=1, frame_cnt incremented.
  - No bubble; no ovf.
- Overflow: attention_vld=1 in SEND on any cycle other than an out_last transfer is dropped.
  - Buffer untouched; ovf=1 next cycle.
- ovf_clr clears ovf next cycle. If a new overflow occurs in the same cycle, the set wins.
- Full frame is 512 beats. Minimum frame period with out_rdy held high is 512 cycles.
- out_rdy is ignored while out_vld=0.
- Pure data movement, no arithmetic. The frame buffer is 8*64*64*DATA_WIDTH flops, written only on capture.

Test Plan:
- Reset, then one vld pulse with element(h,r,c) = h*4096 + r*64 + c, out_rdy=1 -> out_vld rises 1 cycle later; 512 consecutive beats matching the formula; out_last only on beat 511; frame_done 1 cycle after; frame_cnt=1.
- Same frame with out_rdy toggling 1,0,0,1 -> out_data/out_head/out_row stable during stalls; all 512 beats in order; completes in 1024 cycles.
- Second vld issued in the same cycle as out_last -> next cycle shows head 0 / row 0 of frame 2 and frame_done=1; no gap; ovf=0; frame_cnt=2 after frame 2.
- vld pulsed at beat 100 of a frame -> ovf=1 next cycle; remaining beats still carry frame-1 data. ovf_clr pulsed together with another overlapping vld -> ovf stays 1. ovf_clr alone -> ovf=0.
- rst_n=0 for one cycle at beat 300 -> all outputs at reset values next cycle; frame_cnt unchanged from before; a new vld then streams normally from head 0 / row 0.
- Preload frame_cnt to 0xFFFF via 65535 frames (or force), complete one more frame -> frame_cnt=0.
